alu_cmd_arbiter: RTL and testbench

Two-port command arbiter and sequencer for the shared 16-opcode ALU breadboard. Two requesters submit opcode/operand commands over valid/ready handshakes. The block grants one at a time in round-robin order and drives the ALU's opcode and operand inputs for the required number of cycles. It then captures the registered result and carry flag and returns a tagged response, screening divide-by-zero before the ALU is ever driven.

---
 rtl/alu_cmd_arbiter_if.sv | 63 ++++++
 rtl/alu_cmd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_arbiter_if.sv
// rtl/alu_cmd_arbiter_if.sv - bus bundle between requesters, ALU and alu_cmd_arbiter
//
// Purpose: groups every non-clock/reset signal of the arbiter.
// Ports (signals):
//   req0_*/req1_*  : command valid/ready handshake, opcode, operands A/B
//   alu_opcode/a/b : registered drive into the ALU; alu_c/alu_err back from it
//   rsp_*          : tagged response handshake (id, data, ovf, dz)
//   busy, err_cnt  : status
// Modports: master = requesters + ALU + response consumer, slave = arbiter.
interface alu_cmd_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int ERRW  = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [3:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [3:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic [3:0]       alu_opcode;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_c;
   logic             alu_err;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_ovf;
   logic             rsp_dz;

   logic             busy;
   logic [ERRW-1:0]  err_cnt;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_opcode, alu_a, alu_b,
      output alu_c, alu_err,
      input  rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_dz,
      output rsp_ready,
      input  busy, err_cnt
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_opcode, alu_a, alu_b,
      input  alu_c, alu_err,
      output rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_dz,
      input  rsp_ready,
      output busy, err_cnt
   );
endinterface

// File: rtl/alu_cmd_arbiter.sv
// rtl/alu_cmd_arbiter.sv - two-port round-robin command arbiter and sequencer for the shared ALU
//
// Purpose: accepts one command at a time from two requesters, drives the
// registered ALU for ALU_LAT+1 cycles, captures its result/carry and returns
// a tagged response. Divide/modulo by zero is answered without touching the ALU.
// Ports:
//   clk    : clock, all state changes on rising edge
//   reset  : asynchronous active-high reset, aborts any transaction
//   bus    : alu_cmd_arbiter_if.slave (requests, ALU drive/result, response, status)
// Parameters: WIDTH operand width, ALU_LAT ALU latency (1..7), ERRW error counter width.
module alu_cmd_arbiter #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1,
   parameter int ERRW    = 8
) (
   input  logic               clk,
   input  logic               reset,
   alu_cmd_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0] LAST_CNT = 3'(ALU_LAT);
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd4;
   localparam logic [3:0] OP_MOD   = 4'd5;

   state_t           state;
   state_t           state_nx;
   logic             last_grant;
   logic [2:0]       cnt;
   logic [3:0]       cmd_op;

   logic             any_valid;
   logic             grant_id;
   logic             grant_valid;
   logic [3:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             dz_cmd;
   logic             exec_done;
   logic             rsp_hs;

   // Grant selection: on contention give it to the port not served last.
   always_comb begin
      grant_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         grant_id = ~last_grant;
      else if (bus.req1_valid)
         grant_id = 1'b1;
   end

   assign any_valid = bus.req0_valid | bus.req1_valid;
   // Ready is suppressed while reset is held, even though state already reads IDLE.
   assign grant_valid = (state == S_IDLE) && any_valid && !reset;

   assign sel_op = grant_id ? bus.req1_op : bus.req0_op;
   assign sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
   assign sel_b  = grant_id ? bus.req1_b  : bus.req0_b;

   assign dz_cmd    = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_a == '0);
   assign exec_done = (state == S_EXEC) && (cnt == LAST_CNT);
   assign rsp_hs    = (state == S_RESP) && bus.rsp_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (grant_valid)
               state_nx = dz_cmd ? S_RESP : S_EXEC;
         end
         S_EXEC: begin
            if (exec_done)
               state_nx = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      bus.req0_ready = grant_valid & ~grant_id;
      bus.req1_ready = grant_valid &  grant_id;
      bus.rsp_valid  = (state == S_RESP);
      bus.busy       = (state != S_IDLE);
   end

   // Command latch, ALU drive and response capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant     <= 1'b1;
         cnt            <= '0;
         cmd_op         <= '0;
         bus.alu_opcode <= '0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_data   <= '0;
         bus.rsp_ovf    <= 1'b0;
         bus.rsp_dz     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_valid) begin
                  last_grant <= grant_id;
                  cmd_op     <= sel_op;
                  bus.rsp_id <= grant_id;
                  if (dz_cmd) begin
                     // Answered immediately; the ALU keeps seeing opcode 0.
                     bus.rsp_data <= '0;
                     bus.rsp_dz   <= 1'b1;
                     bus.rsp_ovf  <= 1'b0;
                  end else begin
                     bus.alu_opcode <= sel_op;
                     bus.alu_a      <= sel_a;
                     bus.alu_b      <= sel_b;
                     cnt            <= '0;
                  end
               end
            end
            S_EXEC: begin
               if (exec_done) begin
                  bus.rsp_data   <= bus.alu_c;
                  // The ALU flag is a carry only for add; other opcodes leave junk in it.
                  bus.rsp_ovf    <= bus.alu_err & (cmd_op == OP_ADD);
                  bus.rsp_dz     <= 1'b0;
                  bus.alu_opcode <= '0;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Saturating count of errored responses, stepped on the handshake edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bus.err_cnt <= '0;
      else if (rsp_hs && (bus.rsp_ovf || bus.rsp_dz) && (bus.err_cnt != {ERRW{1'b1}}))
         bus.err_cnt <= bus.err_cnt + 1'b1;
   end

endmodule

// File: tb/tb_alu_cmd_arbiter.sv
// tb/tb_alu_cmd_arbiter.sv - self-checking directed bench for alu_cmd_arbiter
module tb_alu_cmd_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   alu_cmd_arbiter_if #(.WIDTH(32), .ERRW(8)) bus ();

   alu_cmd_arbiter #(.WIDTH(32), .ALU_LAT(1), .ERRW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Breadboard ALU: one register stage; carry flag follows A+B for every
   // non-zero opcode so the arbiter's add-only masking is exercised.
   logic [31:0] alu_c_m = '0;
   logic        alu_err_m = 1'b0;
   logic [32:0] sum33;
   assign sum33 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
   assign bus.alu_c = alu_c_m;
   assign bus.alu_err = alu_err_m;

   always @(posedge clk) begin
      if (bus.alu_opcode != 4'd0) begin
         alu_err_m <= sum33[32];
         case (bus.alu_opcode)
            4'd1: alu_c_m <= sum33[31:0];
            4'd2: alu_c_m <= bus.alu_b - bus.alu_a;
            4'd3: alu_c_m <= bus.alu_a * bus.alu_b;
            4'd4: alu_c_m <= (bus.alu_a != 0) ? bus.alu_b / bus.alu_a : 32'd0;
            4'd5: alu_c_m <= (bus.alu_a != 0) ? bus.alu_b % bus.alu_a : 32'd0;
            4'd6: alu_c_m <= bus.alu_a & bus.alu_b;
            default: alu_c_m <= 32'd0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; returns at the negedge after acceptance.
   task automatic do_cmd(input int port, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int t_acc);
      logic seen;
      seen = 1'b0;
      t_acc = -1;
      if (port == 0) begin
         bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
      end else begin
         bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
      end
      for (int i = 0; i < 30; i++) begin
         #1;
         if ((port == 0) ? bus.req0_ready : bus.req1_ready) begin
            seen = 1'b1;
            t_acc = cyc;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("accept_seen", seen, 1'b1);
   endtask

   task automatic wait_rsp(output int t_rsp);
      logic seen;
      seen = 1'b0;
      t_rsp = -1;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (bus.rsp_valid) begin
            seen = 1'b1;
            t_rsp = cyc;
            break;
         end
         @(negedge clk);
      end
      check("rsp_seen", seen, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, r, got;
      int rcyc[4];
      logic both_rdy;

      bus.req0_valid = 1'b1; bus.req0_op = 4'd1; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
      bus.req1_valid = 1'b1; bus.req1_op = 4'd1; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
      bus.rsp_ready = 1'b1;

      // Reset state, with requests pending
      @(negedge clk); @(negedge clk);
      check("rst_req0_ready", bus.req0_ready, 1'b0);
      check("rst_req1_ready", bus.req1_ready, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_err_cnt", bus.err_cnt, 8'd0);
      check("rst_alu_opcode", bus.alu_opcode, 4'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      // Single add on port 0
      do_cmd(0, 4'd1, 32'd5, 32'd7, t);
      check("add_alu_opcode", bus.alu_opcode, 4'd1);
      check("add_alu_a", bus.alu_a, 32'd5);
      check("add_busy", bus.busy, 1'b1);
      wait_rsp(r);
      check("add_latency", r - t, 3);
      check("add_data", bus.rsp_data, 32'd12);
      check("add_ovf", bus.rsp_ovf, 1'b0);
      check("add_dz", bus.rsp_dz, 1'b0);
      check("add_id", bus.rsp_id, 1'b0);
      @(negedge clk);
      check("add_idle_after", bus.busy, 1'b0);

      // Carry out, then the same operands under AND
      do_cmd(0, 4'd1, 32'hFFFF_FFFF, 32'd1, t);
      wait_rsp(r);
      check("carry_data", bus.rsp_data, 32'd0);
      check("carry_ovf", bus.rsp_ovf, 1'b1);
      @(negedge clk);
      check("carry_err_cnt", bus.err_cnt, 8'd1);
      do_cmd(0, 4'd6, 32'hFFFF_FFFF, 32'd1, t);
      wait_rsp(r);
      check("and_data", bus.rsp_data, 32'd1);
      check("and_ovf_masked", bus.rsp_ovf, 1'b0);
      @(negedge clk);
      check("and_err_cnt", bus.err_cnt, 8'd1);

      // Divide by zero on port 1, then a legal modulo
      do_cmd(1, 4'd4, 32'd0, 32'd9, t);
      check("dz_alu_opcode", bus.alu_opcode, 4'd0);
      wait_rsp(r);
      check("dz_latency", r - t, 1);
      check("dz_data", bus.rsp_data, 32'd0);
      check("dz_flag", bus.rsp_dz, 1'b1);
      check("dz_ovf", bus.rsp_ovf, 1'b0);
      check("dz_id", bus.rsp_id, 1'b1);
      @(negedge clk);
      check("dz_err_cnt", bus.err_cnt, 8'd2);
      do_cmd(1, 4'd5, 32'd4, 32'd9, t);
      wait_rsp(r);
      check("mod_data", bus.rsp_data, 32'd1);
      check("mod_dz", bus.rsp_dz, 1'b0);
      @(negedge clk);

      // Contention: both ports valid continuously, expect 0,1,0,1
      bus.req0_op = 4'd2; bus.req0_a = 32'd3; bus.req0_b = 32'd10;
      bus.req1_op = 4'd2; bus.req1_a = 32'd3; bus.req1_b = 32'd10;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      got = 0;
      both_rdy = 1'b0;
      for (int i = 0; i < 60 && got < 4; i++) begin
         #1;
         if (bus.req0_ready && bus.req1_ready) both_rdy = 1'b1;
         if (bus.rsp_valid) begin
            check("cont_data", bus.rsp_data, 32'd7);
            check("cont_id", bus.rsp_id, got[0]);
            rcyc[got] = cyc;
            got++;
            if (got == 4) begin
               bus.req0_valid = 1'b0;
               bus.req1_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      check("cont_count", got, 4);
      check("cont_ready_exclusive", both_rdy, 1'b0);
      if (got == 4) begin
         check("cont_throughput_a", rcyc[1] - rcyc[0], 4);
         check("cont_throughput_b", rcyc[3] - rcyc[2], 4);
      end

      // Response backpressure
      bus.rsp_ready = 1'b0;
      do_cmd(0, 4'd1, 32'd2, 32'd3, t);
      wait_rsp(r);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_rsp_valid", bus.rsp_valid, 1'b1);
         check("bp_data", bus.rsp_data, 32'd5);
         check("bp_busy", bus.busy, 1'b1);
         check("bp_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
         @(negedge clk);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_released_busy", bus.busy, 1'b0);
      check("bp_released_valid", bus.rsp_valid, 1'b0);

      // Reset during the second EXEC cycle
      do_cmd(1, 4'd1, 32'd100, 32'd1, t);
      @(negedge clk);
      check("mid_exec_busy", bus.busy, 1'b1);
      reset = 1'b1;
      #1;
      check("rst_mid_busy", bus.busy, 1'b0);
      check("rst_mid_alu_opcode", bus.alu_opcode, 4'd0);
      check("rst_mid_alu_a", bus.alu_a, 32'd0);
      check("rst_mid_err_cnt", bus.err_cnt, 8'd0);
      check("rst_mid_rsp_id", bus.rsp_id, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_valid", bus.rsp_valid, 1'b0);
      do_cmd(0, 4'd3, 32'd6, 32'd7, t);
      wait_rsp(r);
      check("mul_latency", r - t, 3);
      check("mul_data", bus.rsp_data, 32'd42);
      check("mul_id", bus.rsp_id, 1'b0);
      @(negedge clk);

      // Error counter saturation
      for (int i = 0; i < 260; i++) begin
         do_cmd(0, 4'd5, 32'd0, 32'd1, t);
         wait_rsp(r);
         @(negedge clk);
      end
      check("err_cnt_saturated", bus.err_cnt, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
